// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and the halt/dump controller state type.
package riscv_pkg;

  localparam logic [31:0] ECALL_INSTR  = 32'h0000_0073;
  localparam logic [31:0] EBREAK_INSTR = 32'h0010_0073;
  localparam logic [6:0]  OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [1:0] {
    StRun,
    StDump,
    StDone
  } halt_dump_state_t;

endpackage

// File: rtl/halt_dump_unit.sv
// Halt-and-dump controller: on ECALL, freeze the core and stream a window of dmem words out.
// Optional HALT_DUMP_EBREAK_EN makes EBREAK a trigger as well.
module halt_dump_unit
  import riscv_pkg::*;
#(
  parameter int unsigned ADDR_W     = 5,
  parameter int unsigned DUMP_BASE  = 0,
  parameter int unsigned DUMP_COUNT = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr,
  output logic              halt,
  output logic [ADDR_W-1:0] dmem_raddr,
  input  logic [31:0]       dmem_rdata,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [31:0]       dump_data,
  output logic [ADDR_W-1:0] dump_addr,
  output logic              done,
  output logic [31:0]       cycle_count
);

  localparam int unsigned IdxW    = (DUMP_COUNT > 1) ? $clog2(DUMP_COUNT) : 1;
  localparam int unsigned LastIdx = (DUMP_COUNT > 0) ? DUMP_COUNT - 1 : 0;
  localparam logic [ADDR_W-1:0] BaseAddr = ADDR_W'(DUMP_BASE);

  halt_dump_state_t  state_q, state_d;
  logic [IdxW-1:0]   index_q, index_d;
  logic [31:0]       cycle_q, cycle_d;
  logic              trigger;

`ifdef HALT_DUMP_EBREAK_EN
  assign trigger = (instr == ECALL_INSTR) || (instr == EBREAK_INSTR);
`else
  assign trigger = (instr == ECALL_INSTR);
`endif

  // Modular add: the dump window wraps past the top of dmem.
  assign dmem_raddr  = BaseAddr + ADDR_W'(index_q);
  assign dump_addr   = dmem_raddr;
  assign dump_data   = dmem_rdata;
  assign cycle_count = cycle_q;

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    cycle_d    = cycle_q;
    halt       = 1'b1;
    dump_valid = 1'b0;
    done       = 1'b0;

    unique case (state_q)
      StRun: begin
        // Combinational halt keeps the PC parked on the trigger in its first cycle.
        halt = trigger;
        if (trigger) begin
          index_d = '0;
          state_d = (DUMP_COUNT == 0) ? StDone : StDump;
        end else begin
          cycle_d = cycle_q + 32'd1;
        end
      end
      StDump: begin
        dump_valid = 1'b1;
        if (dump_ready) begin
          if (index_q == IdxW'(LastIdx)) begin
            state_d = StDone;
          end else begin
            index_d = index_q + IdxW'(1);
          end
        end
      end
      StDone: begin
        done = 1'b1;
      end
      default: begin
        state_d = StRun;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StRun;
      index_q <= '0;
      cycle_q <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      cycle_q <= cycle_d;
    end
  end

  valid_hold_a : assert property (@(posedge clk) disable iff (!rst)
    dump_valid && !dump_ready |=> !rst || (dump_valid && $stable(dump_addr)));

  done_sticky_a : assert property (@(posedge clk) disable iff (!rst)
    done |=> !rst || done);

  cycle_frozen_a : assert property (@(posedge clk) disable iff (!rst)
    state_q != StRun |=> !rst || $stable(cycle_q));

endmodule

// File: tb/tb_halt_dump_unit.sv
// Scoreboard bench for halt_dump_unit: a toy PC model feeds instructions, expected dump words
// are queued per run and popped by an independent monitor on each handshake.
module tb_halt_dump_unit;
  import riscv_pkg::*;

  localparam int unsigned AddrW   = 5;
  localparam int unsigned Base    = 28;
  localparam int unsigned Count   = 8;
  localparam int unsigned ProgLen = 16;
`ifdef HALT_DUMP_EBREAK_EN
  localparam bit EbreakEn = 1'b1;
`else
  localparam bit EbreakEn = 1'b0;
`endif

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [31:0]      instr;
  logic             halt;
  logic [AddrW-1:0] dmem_raddr;
  logic [31:0]      dmem_rdata;
  logic             dump_valid;
  logic             dump_ready = 1'b0;
  logic [31:0]      dump_data;
  logic [AddrW-1:0] dump_addr;
  logic             done;
  logic [31:0]      cycle_count;

  logic             halt0;
  logic [AddrW-1:0] raddr0;
  logic [31:0]      rdata0;
  logic             valid0;
  logic [31:0]      data0;
  logic [AddrW-1:0] addr0;
  logic             done0;
  logic [31:0]      cc0;

  logic [31:0] mem  [32];
  logic [31:0] prog [ProgLen];
  logic [3:0]  pc;
  logic        force_ecall = 1'b0;

  int   checks = 0;
  int   fails = 0;
  int   accepted = 0;
  int   exp_cc = 0;
  int   ready_mode = 0;
  int   ready_phase = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  halt_dump_unit #(.ADDR_W(AddrW), .DUMP_BASE(Base), .DUMP_COUNT(Count)) dut (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .halt        (halt),
    .dmem_raddr  (dmem_raddr),
    .dmem_rdata  (dmem_rdata),
    .dump_valid  (dump_valid),
    .dump_ready  (dump_ready),
    .dump_data   (dump_data),
    .dump_addr   (dump_addr),
    .done        (done),
    .cycle_count (cycle_count)
  );

  halt_dump_unit #(.ADDR_W(AddrW), .DUMP_BASE(Base), .DUMP_COUNT(0)) dut_zero (
    .clk         (clk),
    .rst         (rst),
    .instr       (instr),
    .halt        (halt0),
    .dmem_raddr  (raddr0),
    .dmem_rdata  (rdata0),
    .dump_valid  (valid0),
    .dump_ready  (dump_ready),
    .dump_data   (data0),
    .dump_addr   (addr0),
    .done        (done0),
    .cycle_count (cc0)
  );

  assign instr      = force_ecall ? ECALL_INSTR : prog[pc];
  assign dmem_rdata = mem[dmem_raddr];
  assign rdata0     = mem[raddr0];

  // Minimal core: PC advances unless the controller halts it.
  always_ff @(posedge clk) begin
    if (!rst) pc <= '0;
    else if (!halt) pc <= pc + 4'd1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] rand_instr();
    logic [31:0] r;
    r = $urandom;
    if (r == ECALL_INSTR || r == EBREAK_INSTR) r = 32'h0000_0013;
    return r;
  endfunction

  // Sink ready pattern: 0 = always, 1 = 1,0,0 repeating, 2 = random.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0:       dump_ready = 1'b1;
        1:       dump_ready = (ready_phase % 3 == 0);
        default: dump_ready = 1'($urandom_range(0, 1));
      endcase
      ready_phase++;
    end
  end

  // Monitor: pops the scoreboard on every accepted word.
  initial begin
    logic        prev_stall;
    logic        expect_done;
    logic [31:0] prev_addr;
    logic [31:0] prev_data;
    exp_t        e;
    prev_stall  = 1'b0;
    expect_done = 1'b0;
    prev_addr   = '0;
    prev_data   = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_stall  = 1'b0;
        expect_done = 1'b0;
      end else begin
        if (expect_done) begin
          check("done_rise", 32'(done), 32'd1);
          check("done_valid_low", 32'(dump_valid), 32'd0);
          check("done_cycles", cycle_count, exp_cc);
          expect_done = 1'b0;
        end
        if (prev_stall) begin
          check("hold_valid", 32'(dump_valid), 32'd1);
          check("hold_addr", 32'(dump_addr), prev_addr);
          check("hold_data", dump_data, prev_data);
        end
        if (dump_valid) begin
          check("raddr_eq_addr", 32'(dmem_raddr), 32'(dump_addr));
          if (exp_q.size() == 0) begin
            check("extra_word_valid", 32'(dump_valid), 32'd0);
          end else if (dump_ready) begin
            e = exp_q.pop_front();
            check("word_addr", 32'(dump_addr), e.addr);
            check("word_data", dump_data, e.data);
            accepted++;
            if (exp_q.size() == 0) expect_done = 1'b1;
          end
        end
        prev_stall = dump_valid && !dump_ready;
        prev_addr  = 32'(dump_addr);
        prev_data  = dump_data;
        check("zero_never_valid", 32'(valid0), 32'd0);
      end
    end
  end

  task automatic run(input int trig_at, input int eb_at, input int mode, input int abort_after);
    int   trig;
    logic ok;
    @(posedge clk);
    #2;
    rst = 1'b0;
    for (int i = 0; i < ProgLen; i++) prog[i] = rand_instr();
    prog[trig_at] = ECALL_INSTR;
    trig = trig_at;
    if (eb_at >= 0) begin
      prog[eb_at] = EBREAK_INSTR;
      if (EbreakEn && eb_at < trig) trig = eb_at;
    end
    for (int a = 0; a < 32; a++) mem[a] = $urandom;
    ready_mode = mode;
    repeat (2) @(posedge clk);
    #2;
    exp_q.delete();
    for (int i = 0; i < int'(Count); i++) begin
      exp_t e;
      e.addr = (Base + i) % 32;
      e.data = mem[e.addr];
      exp_q.push_back(e);
    end
    exp_cc   = trig;
    accepted = 0;
    rst      = 1'b1;

    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (halt) begin
        ok = 1'b1;
        break;
      end
      check("run_valid_low", 32'(dump_valid), 32'd0);
      check("run_cycle_count", cycle_count, 32'(pc));
    end
    check("halt_seen", 32'(ok), 32'd1);
    if (!ok) return;
    ready_phase = 0;
    check("halt_pc", 32'(pc), trig);
    check("trig_cycle_count", cycle_count, trig);
    check("trig_valid_low", 32'(dump_valid), 32'd0);
    check("zero_cc_at_trig", cc0, trig);
    check("zero_done_pre", 32'(done0), 32'd0);
    @(negedge clk);
    check("valid_rise", 32'(dump_valid), 32'd1);
    check("zero_done_next", 32'(done0), 32'd1);
    check("zero_halt", 32'(halt0), 32'd1);
    check("zero_cc_frozen", cc0, trig);

    ok = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk);
      #2;
      if (abort_after >= 0 && accepted >= abort_after) begin
        rst = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("abort_accepted", accepted, abort_after);
        check("abort_halt", 32'(halt), 32'd0);
        check("abort_valid", 32'(dump_valid), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_cycles", cycle_count, 32'd0);
        check("abort_raddr", 32'(dmem_raddr), Base);
        return;
      end
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    check("done_reached", 32'(ok), 32'd1);
    @(negedge clk);
    check("all_words_taken", exp_q.size(), 32'd0);
    repeat (3) @(negedge clk);
    check("final_cycles_frozen", cycle_count, trig);
    check("final_pc_frozen", 32'(pc), trig);
    check("final_halt", 32'(halt), 32'd1);
    check("final_done_sticky", 32'(done), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < ProgLen; i++) prog[i] = 32'h0000_0013;
    for (int a = 0; a < 32; a++) mem[a] = 32'h0;
    // ECALL present while reset is held must be ignored.
    force_ecall = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_halt_on_ecall", 32'(halt), 32'd1);
    check("rst_valid", 32'(dump_valid), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cycles", cycle_count, 32'd0);
    check("rst_raddr", 32'(dmem_raddr), Base);
    check("rst_addr", 32'(dump_addr), Base);
    check("rst_zero_done", 32'(done0), 32'd0);
    check("rst_zero_addr", 32'(addr0), Base);
    check("rst_zero_data", data0, mem[Base]);
    force_ecall = 1'b0;
    #1;
    check("rst_halt_plain", 32'(halt), 32'd0);

    run(7, -1, 0, -1);
    run($urandom_range(5, 12), -1, 1, -1);
    run(6, -1, 0, 3);
    run(9, -1, 1, -1);
    run(10, 4, 2, -1);
    run($urandom_range(3, 12), -1, 2, -1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/halt_dump_unit.md
# halt_dump_unit

Halt-and-dump controller on the far side of the core's environment-call path. It watches the instruction-memory output and detects ECALL. It then freezes the program counter and streams a window of data-memory words out over a valid/ready port, so a host or bench reads results from hardware instead of peeking at memory. It sits beside `processor_top` between `instr_mem_inst`, `data_mem_inst` and the external result sink.

## Interface
- `ADDR_W`, 5: dmem word-address width.
- `DUMP_BASE`, 0: first dmem word index dumped.
- `DUMP_COUNT`, 8: number of words dumped (0 allowed).
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous, active-low.
- `instr`  in  32  current instruction from instruction memory.
- `halt`  out  1  freezes PC / write-backs when high.
- `dmem_raddr`  out  ADDR_W  dmem word read address; the dmem read is combinational.
- `dmem_rdata`  in  32  dmem read data, same cycle.
- `dump_valid`  out  1  dump word available.
- `dump_ready`  in  1  sink accepts word.
- `dump_data`  out  32  dumped word.
- `dump_addr`  out  ADDR_W  dmem index of `dump_data`.
- `done`  out  1  dump complete, core halted.
- `cycle_count`  out  32  clocks spent in RUN; frozen after halt.

## Operation
- States are RUN, DUMP and DONE. Reset enters RUN with index=0 and cycle_count=0.
- A trigger occurs when `instr == 32'h0000_0073` (ECALL, full-word compare).
- RUN:
  - `halt = trigger`, combinational, so the PC holds on the ECALL instruction in its first cycle.
  - `cycle_count` increments each clock in which no trigger occurs and wraps at 2^32.
  - On a trigger, go to DONE if `DUMP_COUNT == 0`; otherwise go to DUMP with index=0.
- DUMP:
  - `halt = 1`, `dump_valid = 1`.
  - `dmem_raddr = dump_addr = (DUMP_BASE + index) mod 2^ADDR_W`, so addresses wrap past the top of dmem.
  - `dump_data = dmem_rdata`.
  - When `dump_valid && dump_ready` at a clock edge: index increments, or the state moves to DONE if index == DUMP_COUNT-1.
  - When ready is low, address and data hold stable. Valid never drops before acceptance.
- DONE:
  - `halt = 1`, `done = 1`, `dump_valid = 0`.
  - Sticky until reset. Further instr values are ignored.
- `cycle_count` never changes outside RUN.

## Timing
- Reset values (while `rst` is low at an edge, and after): state RUN, `halt=0` unless instr is ECALL, `dump_valid=0`, `done=0`, `dmem_raddr=DUMP_BASE`, `dump_addr=DUMP_BASE`, `cycle_count=0`.
- Latency: the trigger asserts `halt` in the same cycle. `dump_valid` rises on the next edge. Each word needs ≥1 cycle, so the minimum dump is DUMP_COUNT cycles. `done` rises on the edge after the last handshake.
- Continuous ready gives one word per clock.
- Reset during DUMP or DONE aborts the dump, returns to RUN and clears all counters on that edge. The partial dump is not resumed.
- A trigger in the same cycle as reset low is ignored (reset wins).
- `dmem_raddr` is driven in all states (DUMP_BASE+index). It only matters in DUMP.

## Configuration
- `HALT_DUMP_EBREAK_EN`:
  - Defined: `instr == 32'h0010_0073` (EBREAK) is also a trigger, with identical behaviour.
  - Undefined: only ECALL triggers, and EBREAK passes through as a normal instruction (no halt).

## Structure
- The shared package `riscv_pkg` holds:
  - `ECALL_INSTR` and `EBREAK_INSTR` constants;
  - `OPC_SYSTEM = 7'b1110011`;
  - the `halt_dump_state_t` enum (RUN, DUMP, DONE).
- No sub-module is needed. The FSM, index counter and cycle counter live in one module.

## Test plan
- Program computes 500/25 → dmem[7]=20, then ECALL. With `DUMP_BASE=0` and `DUMP_COUNT=8`, ready is held high. Expect:
  - 8 words in consecutive cycles, addr 0..7, word 7 = 20;
  - `done` one cycle after the last word;
  - PC frozen at the ECALL address.
- Backpressure: toggle ready 1,0,0,1,… during the dump. Valid, addr and data must hold while ready=0. Each word is accepted exactly once, in order.
- Wrap: `ADDR_W=5`, `DUMP_BASE=30`, `DUMP_COUNT=4` → addresses 30, 31, 0, 1.
- `DUMP_COUNT=0`: on ECALL, `done` rises on the next edge and `dump_valid` never asserts. `cycle_count` equals the cycles spent before the ECALL.
- Reset mid-dump: drop `rst` after 3 accepted words. The next cycle shows RUN, `halt=0`, `dump_valid=0` and `cycle_count=0`. Re-running the program dumps from addr 0 again.
- EBREAK (`32'h0010_0073`) at address 0x10: with `HALT_DUMP_EBREAK_EN` defined, the dump starts. Undefined, there is no halt and execution continues to the following ECALL.
